// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main sequencing FSM for the multicycle RV32I core.
// Steps the shared ALU, memory port, IR, PC and register file through
// FETCH/DECODE/EXECUTE/WRITEBACK. It drives alu_op to the ALU decoder, flags
// illegal opcodes, and counts retired instructions in instret.
// Optional build macro: MEM_WAIT_EN adds the mem_ready port. With it,
// FETCH, MEMREAD and MEMWRITE stall until memory is ready.

module multicycle_control_fsm #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             op,
  input  logic [2:0]             funct3,
  input  logic                   zero,
`ifdef MEM_WAIT_EN
  input  logic                   mem_ready,
`endif
  output logic                   pc_write,
  output logic                   adr_src,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_write,
  output logic [1:0]             result_src,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             imm_src,
  output logic                   illegal,
  output logic [INSTR_CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [INSTR_CNT_W-1:0] CNT_ONE = INSTR_CNT_W'(1);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t state;
  state_t state_next;

  logic mem_ok;
  logic pc_update;
  logic branch;
  logic pc_write_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic retire;
  logic unused_funct3;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // Only funct3[0] matters here: it picks BEQ versus BNE.
  assign unused_funct3 = ^funct3[2:1];

  // State register. Reset always returns the FSM to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state logic. Unknown encodings fall back to FETCH.
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BR:        state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = mem_ok ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = mem_ok ? FETCH : MEMWRITE;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      JAL:      state_next = ALUWB;
      BRANCH:   state_next = FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  // Moore output decode. Any field not set for a state stays 0.
  // The FETCH enables wait for mem_ok, so each fires only once per fetch.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal       = 1'b0;
    case (state)
      FETCH: begin
        ir_write_raw = mem_ok;
        pc_update    = mem_ok;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode directly, whatever the state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Branch resolution: BEQ is taken on zero=1, BNE on zero=0.
  // While reset is high, every write enable is held off.
  always_comb begin
    pc_write_raw = pc_update | (branch & (zero ^ funct3[0]));
    pc_write     = pc_write_raw  & ~reset;
    mem_write    = mem_write_raw & ~reset;
    ir_write     = ir_write_raw  & ~reset;
    reg_write    = reg_write_raw & ~reset;
  end

  // An instruction retires on the cycle the FSM moves back into FETCH.
  // JAL passes through ALUWB, so it is counted only once there.
  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, ALUWB, BRANCH: retire = 1'b1;
      MEMWRITE:             retire = mem_ok;
      default:              retire = 1'b0;
    endcase
  end

  // Retired-instruction counter. It wraps naturally, and reset beats an
  // increment in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)       instret <= '0;
    else if (retire) instret <= instret + CNT_ONE;
  end

endmodule
